// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the calculator arithmetic units.
//   W_DEF     default operand/result width (two's complement, sign included)
//   LIMIT_DEF default largest result magnitude the decimal display can show
//   ERR_CODE  all-ones pattern reported in place of an overflowing result;
//             slice the low W bits for a given width
//   state_t   sequencing states of the iterative units
package calc_pkg;

  localparam int unsigned W_DEF     = 28;
  localparam int unsigned LIMIT_DEF = 99_999_999;

  localparam logic [63:0] ERR_CODE = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/produs_limit.sv
// produs_limit: combinational result formatter. Turns an unsigned 2W-bit
// magnitude plus a sign into the final W-bit signed result and judges it
// against the display limit. Kept separate so a divider can share it.
//   acc     in  2W  unsigned magnitude of the exact result
//   sgn     in  1   1 = result is negative
//   d_out   out W   signed result, or the overflow code / saturated limit
//   ovr     out 1   1 when acc > LIMIT
module produs_limit
  import calc_pkg::*;
#(
  parameter int unsigned W        = W_DEF,
  parameter int unsigned LIMIT    = LIMIT_DEF,
  parameter bit          SAT_MODE = 1'b0
) (
  input  logic [2*W-1:0] acc,
  input  logic           sgn,
  output logic [W-1:0]   d_out,
  output logic           ovr
);

  localparam logic [2*W-1:0] LIMIT_WIDE = (2*W)'(LIMIT);
  localparam logic [W-1:0]   LIMIT_W    = W'(LIMIT);
  localparam logic [W-1:0]   ERR_W      = ERR_CODE[W-1:0];

  logic [W-1:0] mag;

  always_comb begin
    mag = acc[W-1:0];
    ovr = (acc > LIMIT_WIDE);
    // A zero magnitude negates to zero, so no negative zero can appear.
    if (!ovr) begin
      d_out = sgn ? (W'(0) - mag) : mag;
    end else if (!SAT_MODE) begin
      d_out = ERR_W;
    end else begin
      d_out = sgn ? (W'(0) - LIMIT_W) : LIMIT_W;
    end
  end

endmodule

// File: rtl/produs_seq.sv
// produs_seq: iterative signed multiplier, radix-2 shift-add over W cycles.
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready operand handshake; in_ready is high only in IDLE
//   n1, n2            signed W-bit multiplicand / multiplier
//   out_valid         high in DONE, result held until out_ready
//   out_ready         consumer accepts the result
//   d_out, ovrflow    registered result and overflow flag (update in FIN only)
//   busy              high whenever the unit is not IDLE
module produs_seq
  import calc_pkg::*;
#(
  parameter int unsigned W        = W_DEF,
  parameter int unsigned LIMIT    = LIMIT_DEF,
  parameter bit          SAT_MODE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] n1,
  input  logic [W-1:0] n2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d_out,
  output logic         ovrflow,
  output logic         busy
);

  localparam int unsigned   CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t           state_q, state_d;
  logic [W-1:0]     ma_q, ma_d;
  logic [W-1:0]     mb_q, mb_d;
  logic             sgn_q, sgn_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     d_out_q, d_out_d;
  logic             ovr_q, ovr_d;

  logic [W-1:0]     lim_d_out;
  logic             lim_ovr;

  produs_limit #(
    .W        (W),
    .LIMIT    (LIMIT),
    .SAT_MODE (SAT_MODE)
  ) u_limit (
    .acc   (acc_q),
    .sgn   (sgn_q),
    .d_out (lim_d_out),
    .ovr   (lim_ovr)
  );

  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    d_out_d = d_out_q;
    ovr_d   = ovr_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Magnitudes are held unsigned, so -2^(W-1) maps to 2^(W-1) intact.
          ma_d    = n1[W-1] ? (~n1 + W'(1)) : n1;
          mb_d    = n2[W-1] ? (~n2 + W'(1)) : n2;
          sgn_d   = n1[W-1] ^ n2[W-1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ((n1 == '0) || (n2 == '0)) ? FIN : CALC;
        end
      end
      CALC: begin
        // Always W iterations; no early exit, so latency is data-independent
        // apart from the zero-operand fast path.
        if (mb_q[cnt_q]) begin
          acc_d = acc_q + ((2*W)'(ma_q) << cnt_q);
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIN;
        end
      end
      FIN: begin
        d_out_d = lim_d_out;
        ovr_d   = lim_ovr;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      d_out_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
      ovr_q   <= ovr_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign d_out     = d_out_q;
  assign ovrflow   = ovr_q;

endmodule

// File: tb/tb_produs_seq.sv
// Bench for produs_seq. Two instances (error-code and saturating overflow
// policies) share the same stimulus so both policies are checked together.
module tb_produs_seq;

  localparam int unsigned W     = 28;
  localparam int unsigned LIMIT = 99_999_999;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  n1;
  logic [W-1:0]  n2;

  logic          in_ready0, out_valid0, ovrflow0, busy0;
  logic          in_ready1, out_valid1, ovrflow1, busy1;
  logic [W-1:0]  d_out0, d_out1;

  int checks;
  int failures;
  int lastLatency;

  produs_seq #(.W(W), .LIMIT(LIMIT), .SAT_MODE(1'b0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .n1        (n1),
    .n2        (n2),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .d_out     (d_out0),
    .ovrflow   (ovrflow0),
    .busy      (busy0)
  );

  produs_seq #(.W(W), .LIMIT(LIMIT), .SAT_MODE(1'b1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .n1        (n1),
    .n2        (n2),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .d_out     (d_out1),
    .ovrflow   (ovrflow1),
    .busy      (busy1)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expSat0;
    logic [W-1:0] expSat1;
    logic         expOvr;
    int           expLat;
  } vec_t;

  vec_t vecs[9];

  // One comparison: prints a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents one operand pair, then waits (bounded) for out_valid, recording
  // the number of rising edges from the accept edge to the one raising it
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input string name);
    int  k;
    bit  busyLow;
    bit  seen;
    k = 0;
    while (!in_ready0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, " in_ready before accept"}, 64'(in_ready0), 64'd1);
    @(negedge clk);
    n1       = a;
    n2       = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    busyLow  = 1'b0;
    seen     = 1'b0;
    lastLatency = 0;
    for (int e = 1; e <= 100; e++) begin
      if (!busy0 || !busy1) busyLow = 1'b1;
      @(posedge clk);
      #1;
      if (out_valid0) begin
        lastLatency = e;
        seen = 1'b1;
        break;
      end
    end
    checkOutput({name, " out_valid reached"}, 64'(seen), 64'd1);
    checkOutput({name, " busy throughout"}, 64'(busyLow), 64'd0);
  endtask

  // Accepts the held result and checks the unit returns to IDLE
  task automatic releaseResult(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({name, " out_valid after release"}, 64'(out_valid0), 64'd0);
    checkOutput({name, " in_ready after release"}, 64'(in_ready0), 64'd1);
    checkOutput({name, " busy after release"}, 64'(busy1), 64'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n1        = '0;
    n2        = '0;

    // {a, b, d_out SAT_MODE=0, d_out SAT_MODE=1, ovrflow, latency edges}
    vecs[0] = '{28'sd12345,  -28'sd678,   -28'sd8369910, -28'sd8369910, 1'b0, 29};
    vecs[1] = '{28'sd10000,  28'sd10000,  28'hFFFFFFF,   28'sd99999999, 1'b1, 29};
    vecs[2] = '{28'sd9999,   28'sd10001,  28'sd99999999, 28'sd99999999, 1'b0, 29};
    vecs[3] = '{-28'sd9999,  28'sd10001,  -28'sd99999999, -28'sd99999999, 1'b0, 29};
    vecs[4] = '{28'h8000000, 28'sd1,      28'hFFFFFFF,   -28'sd99999999, 1'b1, 29};
    vecs[5] = '{28'sd0,      -28'sd5,     28'd0,         28'd0,          1'b0, 1};
    vecs[6] = '{28'sd7,      28'sd0,      28'd0,         28'd0,          1'b0, 1};
    vecs[7] = '{28'h8000000, 28'h8000000, 28'hFFFFFFF,   28'sd99999999, 1'b1, 29};
    vecs[8] = '{28'sd10000,  -28'sd10000, 28'hFFFFFFF,   -28'sd99999999, 1'b1, 29};

    #12;
    checkOutput("reset d_out", 64'(d_out0), 64'd0);
    checkOutput("reset out_valid", 64'(out_valid0), 64'd0);
    checkOutput("reset busy", 64'(busy0), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready0), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].a, vecs[i].b, tag);
      checkOutput({tag, " latency"}, 64'(lastLatency), 64'(vecs[i].expLat));
      checkOutput({tag, " d_out sat0"}, 64'(d_out0), 64'(vecs[i].expSat0));
      checkOutput({tag, " d_out sat1"}, 64'(d_out1), 64'(vecs[i].expSat1));
      checkOutput({tag, " ovrflow sat0"}, 64'(ovrflow0), 64'(vecs[i].expOvr));
      checkOutput({tag, " ovrflow sat1"}, 64'(ovrflow1), 64'(vecs[i].expOvr));
      checkOutput({tag, " busy in DONE"}, 64'(busy0), 64'd1);
      releaseResult(tag);
    end

    // Backpressure: result held, in_valid pulses ignored
    begin
      bit unstable;
      applyStimulus(28'sd5, 28'sd6, "bp");
      checkOutput("bp d_out", 64'(d_out0), 64'd30);
      unstable = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        n1       = 28'sd11;
        n2       = 28'sd11;
        in_valid = (c % 2 == 0);
        @(posedge clk);
        #1;
        if (!out_valid0 || d_out0 != 28'd30 || ovrflow0 || in_ready0) unstable = 1'b1;
      end
      in_valid = 1'b0;
      checkOutput("bp held stable", 64'(unstable), 64'd0);
      releaseResult("bp");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bp nothing queued", 64'(busy0), 64'd0);
      applyStimulus(28'sd3, 28'sd4, "bp next");
      checkOutput("bp next d_out", 64'(d_out0), 64'd12);
      releaseResult("bp next");
    end

    // Reset in the middle of CALC abandons the operation
    @(negedge clk);
    n1       = 28'sd100;
    n2       = 28'sd200;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("midrst d_out", 64'(d_out0), 64'd0);
    checkOutput("midrst ovrflow", 64'(ovrflow0), 64'd0);
    checkOutput("midrst out_valid", 64'(out_valid0), 64'd0);
    checkOutput("midrst busy", 64'(busy0), 64'd0);
    checkOutput("midrst in_ready", 64'(in_ready0), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst idle after release", 64'(busy0), 64'd0);
    applyStimulus(-28'sd7, -28'sd6, "postrst");
    checkOutput("postrst d_out", 64'(d_out0), 64'd42);
    checkOutput("postrst ovrflow", 64'(ovrflow0), 64'd0);
    checkOutput("postrst latency", 64'(lastLatency), 64'd29);
    releaseResult("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
